// File: rtl/hack_boot_loader_pkg.sv
// Shared types and constants for the Hack UART program loader.
// BOOT_CHECKSUM_EN adds the CHECK state for the trailing XOR byte.
package hack_boot_loader_pkg;

  localparam logic [7:0]  MAGIC_BYTE = 8'h48;
  localparam int unsigned LEN_W      = 16;

  typedef enum logic [2:0] {
    WAIT_MAGIC,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
`ifdef BOOT_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERR
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/hack_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, one-cycle
// byte_valid on a good stop bit or frame_err on a bad one.
module hack_uart_rx_byte
  import hack_boot_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_t     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          st_d    = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_data  = sh_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/hack_boot_loader.sv
// Framed UART program loader writing words into the Hack instruction ROM
// and holding the CPU in reset while loading. Option: BOOT_CHECKSUM_EN.
module hack_boot_loader
  import hack_boot_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ROM_DEPTH    = 32768,
  parameter int unsigned TIMEOUT_CLKS = 10_000_000
) (
  input  logic        CLK_100MHz,
  input  logic        RESET,
  input  logic        BOOT_RX,
  output logic        ROM_WE,
  output logic [15:0] ROM_ADDR,
  output logic [15:0] ROM_DATA,
  output logic        CPU_HOLD,
  output logic        LOADED,
  output logic        ERROR
);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t LAST_STATE = CHECK;
`else
  localparam boot_state_t LAST_STATE = DONE;
`endif

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;

  hack_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (CLK_100MHz),
    .rst        (RESET),
    .rx         (BOOT_RX),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  boot_state_t      state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic             we_q, we_d;
  logic             hold_q, hold_d;
  logic             loaded_q, loaded_d;
  logic             error_q, error_d;
  logic [7:0]       hi_q, hi_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      tmo_q, tmo_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic [LEN_W-1:0] len_w;
  logic             in_frame;
  logic             go_err;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    hold_d   = hold_q;
    loaded_d = loaded_q;
    error_d  = error_q;
    hi_d     = hi_q;
    rem_d    = rem_q;
    go_err   = 1'b0;
    len_w    = {hi_q, byte_data};
    in_frame = (state_q != WAIT_MAGIC) && (state_q != DONE) && (state_q != ERR);

    // tmo_q counts clocks since the last byte_valid, so ERROR lands exactly
    // TIMEOUT_CLKS cycles after it
    if (byte_valid)    tmo_d = 32'd1;
    else if (in_frame) tmo_d = tmo_q + 32'd1;
    else               tmo_d = '0;

    if (we_q) addr_d = addr_q + 16'd1;

    if (state_q == DONE) begin
      loaded_d = 1'b1;
      hold_d   = 1'b0;
    end

    case (state_q)
      WAIT_MAGIC, DONE, ERR: begin
        if (byte_valid && byte_data == MAGIC_BYTE) begin
          state_d  = LEN_HI;
          loaded_d = 1'b0;
          error_d  = 1'b0;
          hold_d   = 1'b1;
          addr_d   = '0;
        end
      end
      LEN_HI: begin
        if (byte_valid) begin
          hi_d    = byte_data;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (byte_valid) begin
          rem_d = len_w;
          if (len_w == '0)                     state_d = LAST_STATE;
          else if (32'(len_w) > ROM_DEPTH)     go_err  = 1'b1;
          else                                 state_d = DATA_HI;
        end
      end
      DATA_HI: begin
        if (byte_valid) begin
          hi_d    = byte_data;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (byte_valid) begin
          we_d    = 1'b1;
          data_d  = {hi_q, byte_data};
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? LAST_STATE : DATA_HI;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CHECK: begin
        if (byte_valid) begin
          if (byte_data == csum_q) state_d = DONE;
          else                     go_err  = 1'b1;
        end
      end
`endif
      default: ;
    endcase

`ifdef BOOT_CHECKSUM_EN
    csum_d = csum_q;
    if (byte_valid && state_q == LEN_HI) csum_d = byte_data;
    else if (byte_valid && (state_q == LEN_LO || state_q == DATA_HI || state_q == DATA_LO))
      csum_d = csum_q ^ byte_data;
`endif

    if (in_frame && frame_err) go_err = 1'b1;
    if (in_frame && !byte_valid && tmo_q == TIMEOUT_CLKS - 1) go_err = 1'b1;

    if (go_err) begin
      state_d = ERR;
      error_d = 1'b1;
      hold_d  = 1'b1;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      state_q  <= WAIT_MAGIC;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      hold_q   <= 1'b0;
      loaded_q <= 1'b0;
      error_q  <= 1'b0;
      hi_q     <= '0;
      rem_q    <= '0;
      tmo_q    <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      hold_q   <= hold_d;
      loaded_q <= loaded_d;
      error_q  <= error_d;
      hi_q     <= hi_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign ROM_WE   = we_q;
  assign ROM_ADDR = addr_q;
  assign ROM_DATA = data_q;
  assign CPU_HOLD = hold_q;
  assign LOADED   = loaded_q;
  assign ERROR    = error_q;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Directed bench for hack_boot_loader: a frame-level parser predicts the ROM
// writes and final flags; one negedge process checks every strobe.
module tb_hack_boot_loader;

  localparam int unsigned CPB   = 16;
  localparam int unsigned TMO   = 1000;
  localparam int unsigned DEPTH = 32768;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        rom_we, cpu_hold, loaded, error;
  logic [15:0] rom_addr, rom_data;

  always #5 clk = ~clk;

  hack_boot_loader #(.CLKS_PER_BIT(CPB), .ROM_DEPTH(DEPTH), .TIMEOUT_CLKS(TMO)) u_dut (
    .CLK_100MHz (clk),
    .RESET      (rst),
    .BOOT_RX    (rx),
    .ROM_WE     (rom_we),
    .ROM_ADDR   (rom_addr),
    .ROM_DATA   (rom_data),
    .CPU_HOLD   (cpu_hold),
    .LOADED     (loaded),
    .ERROR      (error)
  );

  typedef struct packed { logic [15:0] addr; logic [15:0] data; } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  wr_t         seen_q[$];
  wr_t         w;
  logic [7:0]  frm[$];
  logic        exp_loaded, exp_error, exp_hold;
  logic [15:0] exp_addr;
  int          cyc = 0, bv_cyc = -1, err_cyc = -1;
  logic        prev_we = 1'b0, prev_bv = 1'b0, prev_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every strobe must follow a byte_valid, never be back-to-back, and match
  // the next predicted write.
  always @(negedge clk) begin
    cyc++;
    if (u_dut.byte_valid) bv_cyc = cyc;
    if (error && !prev_err) err_cyc = cyc;
    if (rom_we) begin
      check("we_after_byte", {31'd0, prev_bv}, 32'd1);
      check("we_not_b2b", {31'd0, prev_we}, 32'd0);
      check("we_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("we_addr", {16'd0, rom_addr}, {16'd0, w.addr});
        check("we_data", {16'd0, rom_data}, {16'd0, w.data});
      end
      seen_q.push_back({rom_addr, rom_data});
    end
    prev_we  = rom_we;
    prev_bv  = u_dut.byte_valid;
    prev_err = error;
  end

  task automatic add_csum(input logic corrupt);
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < frm.size(); i++) x ^= frm[i];
    frm.push_back(x ^ {7'd0, corrupt});
`else
    if (corrupt) frm = frm;
`endif
  endtask

  // Parse the frame in frm as a whole; bad = index of the byte sent with a
  // zero stop bit (-1: none).
  task automatic model_frame(input int bad);
    int unsigned len;
    logic [7:0]  x;
    exp_loaded = 1'b0; exp_error = 1'b0; exp_hold = 1'b1; exp_addr = 16'd0;
    if (bad == 1 || bad == 2) begin exp_error = 1'b1; return; end
    len = {frm[1], frm[2]};
    x   = frm[1] ^ frm[2];
    if (len > DEPTH) begin exp_error = 1'b1; return; end
    for (int unsigned k = 0; k < len; k++) begin
      if (bad == int'(3 + 2 * k) || bad == int'(4 + 2 * k)) begin exp_error = 1'b1; return; end
      x ^= frm[3 + 2 * k] ^ frm[4 + 2 * k];
      exp_q.push_back({exp_addr, frm[3 + 2 * k], frm[4 + 2 * k]});
      exp_addr++;
    end
`ifdef BOOT_CHECKSUM_EN
    if (bad == int'(3 + 2 * len) || frm[3 + 2 * len] != x) begin exp_error = 1'b1; return; end
`endif
    exp_loaded = 1'b1;
    exp_hold   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_range(input int lo, input int hi, input int bad);
    for (int i = lo; i <= hi; i++) send_byte(frm[i], i != bad);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_loaded"}, {31'd0, loaded}, {31'd0, exp_loaded});
    check({tag, "_error"},  {31'd0, error},  {31'd0, exp_error});
    check({tag, "_hold"},   {31'd0, cpu_hold}, {31'd0, exp_hold});
    check({tag, "_addr"},   {16'd0, rom_addr}, {16'd0, exp_addr});
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int bad);
    model_frame(bad);
    send_range(0, (bad < 0) ? frm.size() - 1 : bad, bad);
    repeat (4 * CPB) @(negedge clk);
    check_flags(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_we",     {31'd0, rom_we},   32'd0);
    check("rst_addr",   {16'd0, rom_addr}, 32'd0);
    check("rst_data",   {16'd0, rom_data}, 32'd0);
    check("rst_hold",   {31'd0, cpu_hold}, 32'd0);
    check("rst_loaded", {31'd0, loaded},   32'd0);
    check("rst_error",  {31'd0, error},    32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Two-word load; hold must be up before the payload arrives.
    frm = '{8'h48, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    add_csum(1'b0);
    model_frame(-1);
    seen_q.delete();
    send_range(0, 0, -1);
    repeat (4) @(negedge clk);
    check("magic_hold", {31'd0, cpu_hold}, 32'd1);
    check("magic_loaded", {31'd0, loaded}, 32'd0);
    send_range(1, frm.size() - 1, -1);
    repeat (4 * CPB) @(negedge clk);
    check_flags("two_words");
    check("lit_writes", seen_q.size(), 32'd2);
    if (seen_q.size() == 2) begin
      check("lit_w0", seen_q[0], 32'h0000_1234);
      check("lit_w1", seen_q[1], 32'h0001_ABCD);
    end
    check("lit_loaded", {31'd0, loaded}, 32'd1);
    check("lit_hold", {31'd0, cpu_hold}, 32'd0);

    // A stray non-magic byte in DONE changes nothing.
    send_byte(8'h5A, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check_flags("trailing");

    frm = '{8'h48, 8'h00, 8'h00};
    add_csum(1'b0);
    run_frame("len_zero", -1);

    frm = '{8'h48, 8'h80, 8'h01};
    run_frame("len_over", -1);
    check("lit_over_error", {31'd0, error}, 32'd1);

    // Second word's low byte has a bad stop bit: word 0 stays written.
    frm = '{8'h48, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    run_frame("stop_err", 6);
    check("lit_stop_addr", {16'd0, rom_addr}, 32'd1);

    frm = '{8'h48, 8'h00, 8'h02, 8'h0F, 8'hF0, 8'h77, 8'h01};
    add_csum(1'b0);
    run_frame("recover", -1);

    // Stall after the length high byte.
    frm = '{8'h48, 8'h00};
    exp_loaded = 1'b0; exp_error = 1'b1; exp_hold = 1'b1; exp_addr = 16'd0;
    err_cyc = -1;
    send_range(0, 1, -1);
    for (int i = 0; i < int'(TMO) + 200 && !error; i++) @(negedge clk);
    @(negedge clk);
    check("timeout_fired", {31'd0, error}, 32'd1);
    check("timeout_delay", err_cyc - bv_cyc, TMO);
    check_flags("timeout");

    // Reset after the first word is in.
    frm = '{8'h48, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    exp_q.push_back({16'h0000, 16'h1234});
    send_range(0, 4, -1);
    repeat (4) @(negedge clk);
    check("pre_rst_written", exp_q.size(), 32'd0);
    check("pre_rst_addr", {16'd0, rom_addr}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_we",     {31'd0, rom_we},   32'd0);
    check("mid_rst_addr",   {16'd0, rom_addr}, 32'd0);
    check("mid_rst_data",   {16'd0, rom_data}, 32'd0);
    check("mid_rst_hold",   {31'd0, cpu_hold}, 32'd0);
    check("mid_rst_loaded", {31'd0, loaded},   32'd0);
    check("mid_rst_error",  {31'd0, error},    32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    add_csum(1'b0);
    run_frame("after_rst", -1);

    // Wrong checksum byte (only meaningful with the checksum option).
    frm = '{8'h48, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    add_csum(1'b1);
    run_frame("bad_csum", -1);

    // Quarter-bit low glitch while waiting for the length high byte.
    frm = '{8'h48, 8'h00, 8'h01, 8'h55, 8'h66};
    add_csum(1'b0);
    model_frame(-1);
    send_range(0, 0, -1);
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_hold", {31'd0, cpu_hold}, 32'd1);
    check("glitch_error", {31'd0, error}, 32'd0);
    send_range(1, frm.size() - 1, -1);
    repeat (4 * CPB) @(negedge clk);
    check_flags("glitch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
